// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family and its adapters.
package fifo_pkg;

  localparam int SKID_DEPTH = 2;

  // Skid-buffer occupancy; legal values are 0..SKID_DEPTH.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO that decouples the stream output from the FIFO read port.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  occ_t             occ_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((occ_q != occ_t'(SKID_DEPTH)) || pop);
  assign do_pop  = pop && (occ_q != 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the data entries are reset as well, not just occupancy, so the
      // stream output reads zero while the reader is held in reset.
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// at up to one word per cycle, with flush and a completed-beat counter.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] xfer_count
);

  logic       inflight;
  logic       drop;
  logic       pop;
  logic       push;
  logic [1:0] occ;
  logic [2:0] demand;

  assign pop = m_valid & m_ready;

  // Words already owned by the reader after this cycle's pop; pop implies
  // occ >= 1, so the 3-bit difference never goes negative.
  assign demand = 3'(occ) + 3'(inflight) - 3'(pop);

  assign fifo_rd_en = rstn & enable & ~flush & ~fifo_empty
                    & (demand < 3'(SKID_DEPTH));

  // A word returning during a flush, or just after one, is discarded.
  assign push = inflight & ~drop & ~flush;

  assign m_valid = (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight   <= 1'b0;
      drop       <= 1'b0;
      xfer_count <= '0;
    end else begin
      // fifo_rd_en already includes !fifo_empty, so it marks an accepted read.
      inflight <= fifo_rd_en;
      drop     <= flush;
      if (pop) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader driving a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             enable;
  logic             flush;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] xfer_count;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  logic [CNT_W-1:0] exp_count;
  logic [WIDTH-1:0] mem[$];
  logic [WIDTH-1:0] got_q[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_count (xfer_count)
  );

  // FIFO model: registered empty flag, data valid the cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) fifo_data <= mem.pop_front();
    fifo_empty <= (mem.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_rd_en && !fifo_empty) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned at the negedge of the first accepted-read cycle.
  task automatic wait_read(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) begin
        found = 1'b1;
        break;
      end
      if (i < 9) tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_read: fifo_rd_en never asserted within 10 cycles");
    end
  endtask

  task automatic collect(input int n, input int budget);
    got_q.delete();
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) got_q.push_back(m_data);
      tick();
    end
  endtask

  task automatic check_count(input string name);
    @(negedge clk);
    checks++;
    if (xfer_count !== exp_count) begin
      errors++;
      $display("FAIL %s xfer_count: got %0d expected %0d", name, xfer_count, exp_count);
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; flush = 1'b0; m_ready = 1'b1;
    mem = '{8'h01, 8'h02, 8'h03};
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checks += 4;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en c%0d: got %b expected 0", c, fifo_rd_en); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid c%0d: got %b expected 0", c, m_valid); end
      if (m_data !== 8'h00) begin errors++; $display("FAIL reset m_data c%0d: got %h expected 00", c, m_data); end
      if (xfer_count !== 4'd0) begin errors++; $display("FAIL reset xfer_count c%0d: got %0d expected 0", c, xfer_count); end
    end
    tick();
    mem.delete();
    enable = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_count = '0;
    tick();
  endtask

  task automatic test_streaming();
    bit found;
    bit exp_v;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem.push_back(8'h10 + 8'(i));
    wait_read(found);
    tick();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_v = (c >= 2 && c <= 9);
      checks++;
      if (m_valid !== exp_v) begin
        errors++;
        $display("FAIL stream m_valid T+%0d: got %b expected %b", c, m_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (m_data !== 8'h10 + 8'(c - 2)) begin
          errors++;
          $display("FAIL stream m_data T+%0d: got %h expected %h", c, m_data, 8'h10 + 8'(c - 2));
        end
      end
      tick();
    end
    exp_count = exp_count + 4'd8;
    check_count("stream");
  endtask

  task automatic test_backpressure();
    bit found;
    int rd0;
    rd0 = rd_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) mem.push_back(8'hA0 + 8'(i));
    wait_read(found);
    tick();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
          errors++;
          $display("FAIL bp hold T+%0d: got valid=%b data=%h expected valid=1 data=a0", c, m_valid, m_data);
        end
      end
      tick();
    end
    checks++;
    if (rd_cnt - rd0 != 2) begin
      errors++;
      $display("FAIL bp reads_stalled: got %0d expected 2", rd_cnt - rd0);
    end
    m_ready = 1'b1;
    collect(5, 30);
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL bp beats: got %0d expected 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      checks++;
      if (got_q[i] !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL bp order[%0d]: got %h expected %h", i, got_q[i], 8'hA0 + 8'(i));
      end
    end
    checks++;
    if (rd_cnt - rd0 != 5) begin
      errors++;
      $display("FAIL bp reads_total: got %0d expected 5", rd_cnt - rd0);
    end
    exp_count = exp_count + 4'd5;
    check_count("bp");
  endtask

  task automatic test_empty_boundary();
    int rd0;
    rd0 = rd_cnt;
    m_ready = 1'b1;
    mem.push_back(8'h5A);
    collect(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL empty beat: got %0d beats first=%h expected 1 beat 5a",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL empty idle c%0d: got rd_en=%b m_valid=%b empty=%b expected 0 0 1",
                 c, fifo_rd_en, m_valid, fifo_empty);
      end
      tick();
    end
    checks++;
    if (rd_cnt - rd0 != 1) begin
      errors++;
      $display("FAIL empty reads: got %0d expected 1", rd_cnt - rd0);
    end
    exp_count = exp_count + 4'd1;
    check_count("empty");
  endtask

  task automatic test_flush();
    bit found;
    m_ready = 1'b0;
    mem.push_back(8'h32);
    mem.push_back(8'h33);
    mem.push_back(8'h34);
    wait_read(found);
    tick();
    @(negedge clk);
    checks++;
    if (!(fifo_rd_en && !fifo_empty)) begin
      errors++;
      $display("FAIL flush read_33: got rd_en=%b empty=%b expected accepted read", fifo_rd_en, fifo_empty);
    end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h32) begin
      errors++;
      $display("FAIL flush cycle: got rd_en=%b valid=%b data=%h expected 0 1 32", fifo_rd_en, m_valid, m_data);
    end
    tick();
    flush = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush after m_valid: got %b expected 0", m_valid);
    end
    tick();
    collect(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h34) begin
      errors++;
      $display("FAIL flush next_word: got %0d beats first=%h expected 1 beat 34",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush tail m_valid c%0d: got %b expected 0", c, m_valid);
      end
      tick();
    end
    exp_count = exp_count + 4'd1;
    check_count("flush");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_q[$];
    int rd0;
    int beats;
    rstn = 1'b0; enable = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_count = '0;
    check_count("rand_reset");
    for (int i = 0; i < 100; i++) begin
      mem.push_back(8'(i * 37 + 11));
      exp_q.push_back(8'(i * 37 + 11));
    end
    rd0 = rd_cnt;
    beats = 0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 3000 && beats < 100; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== exp_q[beats]) begin
          errors++;
          $display("FAIL rand beat %0d: got %h expected %h", beats, m_data, exp_q[beats]);
        end
        beats++;
      end
      tick();
      checks++;
      if (rd_cnt - rd0 - beats > 2 || rd_cnt - rd0 - beats < 0) begin
        errors++;
        $display("FAIL rand outstanding: got %0d expected 0..2", rd_cnt - rd0 - beats);
      end
    end
    checks++;
    if (beats != 100) begin
      errors++;
      $display("FAIL rand beats: got %0d expected 100", beats);
    end
    exp_count = 4'd4;
    check_count("rand");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain-side adapter for the team's synchronous FIFO.
- Issues `fifo_rd_en` against the FIFO's registered `empty` flag and absorbs the FIFO's 1-cycle read latency.
- Presents the data as a valid/ready stream (`m_valid`/`m_ready`/`m_data`) through an internal 2-entry skid buffer, so throughput is 1 word/cycle under no backpressure.
- Sits between the FIFO read port and any downstream stream consumer.

Parameters:
WIDTH, 8, data word width; must match the FIFO's WIDTH.
CNT_W, 16, width of the transfer counter `xfer_count`.

Ports:
clk  input  1  clock; all logic is rising-edge.
rstn  input  1  synchronous, active-low reset.
enable  input  1  permits new FIFO reads when high.
flush  input  1  synchronous discard of buffered and in-flight data.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read enable.
fifo_data  input  WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
m_valid  output  1  stream data valid.
m_ready  input  1  downstream ready.
m_data  output  WIDTH  stream data.
xfer_count  output  CNT_W  count of completed stream beats.

Behaviour:
- Reset: `rstn` is synchronous, active-low; clock is `clk`. While `rstn`=0 at a rising edge:
  - buffer occupancy=0, in-flight flag=0, drop flag=0;
  - `m_valid`=0, `m_data`=0, `xfer_count`=0;
  - `fifo_rd_en`=0 combinationally whenever `rstn`=0.
- Reset mid-operation: buffered and in-flight words are lost; no beat is emitted for them.
- Definitions:
  - Accepted read = `fifo_rd_en` & !`fifo_empty` in the same cycle.
  - inflight = 1 in the cycle after an accepted read, else 0.
  - pop = `m_valid` & `m_ready`.
  - occ = skid-buffer occupancy, 0..2.
- Read issue (combinational): `fifo_rd_en` = `rstn` & `enable` & !`flush` & !`fifo_empty` & ((occ + inflight − pop) < 2).
  - Depends combinationally on `m_ready`; downstream must not route `fifo_rd_en` back into `m_ready`.
  - Computed in 3 bits; the result is never negative because pop implies occ ≥ 1.
- Capture: when inflight=1 and drop=0, `fifo_data` is written to the buffer tail at the rising edge ending that cycle.
  - Simultaneous capture and pop: occ is unchanged, and FIFO order is preserved.
- Output:
  - `m_valid` = (occ != 0); `m_data` = buffer head.
  - Both come directly from registers (no combinational path from `fifo_data`).
  - With `m_valid`=1 and `m_ready`=0, `m_data` holds stable until accepted.
- Latency:
  - Accepted read in cycle T → `m_valid`=1 in cycle T+2, if the buffer was empty.
  - Steady state with `m_ready`=1: occ=1, inflight=1, one read and one beat per cycle.
- Backpressure: occ+inflight never exceeds 2, so the buffer never overflows and no FIFO word is read that cannot be stored.
- `enable` low: no new reads; in-flight and buffered words are still delivered.
- `fifo_empty` boundary: with exactly one word in the FIFO, one `fifo_rd_en` pulse is accepted. A read asserted while `fifo_empty`=1 has no effect and does not set inflight.
- Flush, cycle F:
  - `fifo_rd_en`=0;
  - at the edge: occ←0;
  - if inflight=1 in F+1, that returning word is discarded (drop flag set at F, cleared at F+1);
  - `m_valid`=0 in F+1;
  - a pop in cycle F still counts.
  - Flush dominates `enable`. `xfer_count` is not cleared by flush.
- `xfer_count`: increments by 1 on each pop; wraps modulo 2^CNT_W.

Decomposition:
- Package `fifo_pkg`: occupancy typedef (`logic [1:0]`, 0..2) and localparam `SKID_DEPTH`=2, shared with future FIFO-side blocks.
- Sub-module `fifo_skid_buf`:
  - a 2-entry register FIFO with push/pop/clear, head output and occ output;
  - `fifo_stream_reader` wraps it with the read-issue, inflight/drop tracking and counter logic.

Test Plan:
1. Reset: hold `rstn`=0 for 3 cycles with `fifo_empty`=0, `enable`=1 → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `xfer_count`=0 throughout.
2. Streaming: FIFO preloaded with 0x10..0x17, `m_ready`=1 → first `fifo_rd_en` in cycle T, `m_valid`=1 from T+2 for 8 consecutive cycles carrying 0x10..0x17 in order, `xfer_count`=8.
3. Backpressure: 5 words 0xA0..0xA4, `m_ready`=0 → exactly 2 accepted reads, `m_data`=0xA0 held stable. Raise `m_ready` → 0xA0..0xA4 in order, no loss or duplication.
4. Empty boundary: single word 0x5A, `m_ready`=1 → one accepted read, one beat 0x5A. The FIFO then reports empty and `fifo_rd_en` stays 0.
5. Flush: assert `flush` in the cycle after an accepted read of 0x33 while occ=1 → no beat of 0x33 or the buffered word, `m_valid`=0 next cycle. Next FIFO word 0x34 is delivered normally.
6. Random: `m_ready` random at 50%, 100 words, CNT_W=4 → scoreboard order matches, `xfer_count`=4 (100 mod 16), occ+inflight ≤ 2 asserted every cycle.
